// File: rtl/register_pkg.sv
// Shared definitions for the register bank: write-mode encodings and the
// mode type used by the top level and by every storage cell.
package register_pkg;

    // Encodings match the wr_mode port: 00 LOAD, 01 SHL, 10 SHR, 11 INCR.
    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_INCR = 2'b11
    } wr_mode_e;

    localparam int MODE_WIDTH = 2;

    // True for modes that rewrite the register from its own stored value.
    function automatic logic mode_is_in_place(input wr_mode_e mode);
        return (mode != MODE_LOAD);
    endfunction

endpackage : register_pkg

// File: rtl/register_cell.sv
// One storage register of the bank: value, valid bit and the in-place
// mode datapath. The cell reports the carry/shift-out that the selected mode
// would produce from its current value; the top level registers the flag of
// whichever cell is being written.
module register_cell
    import register_pkg::*;
#(
    parameter int BIT_COUNT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear_i,
    input  logic                 we_i,
    input  wr_mode_e             mode_i,
    input  logic [BIT_COUNT-1:0] data_i,
    input  logic                 shift_in_i,
    output logic [BIT_COUNT-1:0] value_o,
    output logic                 valid_o,
    output logic                 flag_nxt_o
);

    localparam logic [BIT_COUNT-1:0] ONE = {{(BIT_COUNT-1){1'b0}}, 1'b1};

    logic [BIT_COUNT-1:0] value_q;
    logic [BIT_COUNT-1:0] value_d;
    logic                 valid_q;

    // Mode datapath: next value and the bit that falls out of the register.
    // An unwritten register holds 0, so modes on it operate on 0.
    always_comb begin
        value_d    = value_q;
        flag_nxt_o = 1'b0;
        case (mode_i)
            MODE_LOAD: begin
                value_d    = data_i;
                flag_nxt_o = 1'b0;
            end
            MODE_SHL: begin
                value_d    = {value_q[BIT_COUNT-2:0], shift_in_i};
                flag_nxt_o = value_q[BIT_COUNT-1];
            end
            MODE_SHR: begin
                value_d    = {shift_in_i, value_q[BIT_COUNT-1:1]};
                flag_nxt_o = value_q[0];
            end
            MODE_INCR: begin
                value_d    = value_q + ONE;
                flag_nxt_o = &value_q;
            end
            default: begin
                value_d    = value_q;
                flag_nxt_o = 1'b0;
            end
        endcase
    end

    // Storage: clear wins over a write; any accepted write marks the cell valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            value_q <= '0;
            valid_q <= 1'b0;
        end else if (we_i) begin
            value_q <= value_d;
            valid_q <= 1'b1;
        end
    end

    assign value_o = value_q;
    assign valid_o = valid_q;

endmodule : register_cell

// File: rtl/register_bank.sv
// Register bank: REG_COUNT x BIT_COUNT operand/accumulator store with one
// write port (LOAD / SHL / SHR / INCR), two combinational read ports,
// per-register valid bits, a registered carry/shift-out flag and a one-cycle
// pulse for out-of-range writes.
//
// Build option REGISTER_BANK_BYPASS_EN: when defined, an in-range LOAD that
// is not overridden by clear_all is forwarded to any read port addressing the
// target in the same cycle. In-place modes are never forwarded because their
// result depends on the stored value and would lengthen the read path.
module register_bank
    import register_pkg::*;
#(
    parameter  int BIT_COUNT  = 8,
    parameter  int REG_COUNT  = 4,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_all,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [MODE_WIDTH-1:0] wr_mode,
    input  logic [BIT_COUNT-1:0]  wr_data,
    input  logic                  shift_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [BIT_COUNT-1:0]  rd_data_a,
    output logic                  rd_valid_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [BIT_COUNT-1:0]  rd_data_b,
    output logic                  rd_valid_b,
    output logic                  wr_flag,
    output logic                  addr_err
);

    // One extra bit so REG_COUNT itself is representable for the range check.
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);

    wr_mode_e             mode;
    logic                 wr_in_range;
    logic                 wr_accept;
    logic [REG_COUNT-1:0] cell_we;
    logic [BIT_COUNT-1:0] cell_value [REG_COUNT];
    logic [REG_COUNT-1:0] cell_valid;
    logic [REG_COUNT-1:0] cell_flag;
    logic                 flag_sel;

    logic wr_flag_q;
    logic wr_flag_d;
    logic addr_err_q;
    logic addr_err_d;

    assign mode        = wr_mode_e'(wr_mode);
    assign wr_in_range = ({1'b0, wr_addr} < REG_LIMIT);
    assign wr_accept   = wr_en && wr_in_range && !clear_all;

    // Address decode into per-cell write enables, and pick the addressed
    // cell's carry/shift-out for the flag register.
    always_comb begin
        cell_we  = '0;
        flag_sel = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_addr == ADDR_WIDTH'(i)) begin
                cell_we[i] = wr_accept;
                flag_sel   = cell_flag[i];
            end
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_cell
        register_cell #(
            .BIT_COUNT (BIT_COUNT)
        ) u_cell (
            .clk        (clk),
            .reset_n    (reset_n),
            .clear_i    (clear_all),
            .we_i       (cell_we[g]),
            .mode_i     (mode),
            .data_i     (wr_data),
            .shift_in_i (shift_in),
            .value_o    (cell_value[g]),
            .valid_o    (cell_valid[g]),
            .flag_nxt_o (cell_flag[g])
        );
    end

    // Next flag and error pulse: flag follows accepted writes only, the error
    // pulse marks an out-of-range request that clear_all did not override.
    always_comb begin
        wr_flag_d  = wr_flag_q;
        addr_err_d = 1'b0;
        if (clear_all) begin
            wr_flag_d = 1'b0;
        end else if (wr_en) begin
            if (wr_in_range) begin
                wr_flag_d = flag_sel;
            end else begin
                addr_err_d = 1'b1;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_flag_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wr_flag_q  <= wr_flag_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign wr_flag  = wr_flag_q;
    assign addr_err = addr_err_q;

`ifdef REGISTER_BANK_BYPASS_EN
    logic fwd_load;
    assign fwd_load = wr_accept && (mode == MODE_LOAD);
`endif

    // Read port A: stored value, 0/invalid when out of range.
    always_comb begin
        rd_data_a  = '0;
        rd_valid_a = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (rd_addr_a == ADDR_WIDTH'(i)) begin
                rd_data_a  = cell_value[i];
                rd_valid_a = cell_valid[i];
            end
        end
`ifdef REGISTER_BANK_BYPASS_EN
        if (fwd_load && (rd_addr_a == wr_addr)) begin
            rd_data_a  = wr_data;
            rd_valid_a = 1'b1;
        end
`endif
    end

    // Read port B: identical to port A, independent address.
    always_comb begin
        rd_data_b  = '0;
        rd_valid_b = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (rd_addr_b == ADDR_WIDTH'(i)) begin
                rd_data_b  = cell_value[i];
                rd_valid_b = cell_valid[i];
            end
        end
`ifdef REGISTER_BANK_BYPASS_EN
        if (fwd_load && (rd_addr_b == wr_addr)) begin
            rd_data_b  = wr_data;
            rd_valid_b = 1'b1;
        end
`endif
    end

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Bench for register_bank with REG_COUNT=5 so that addresses 5..7 are out of
// range. Reference model: integer array of register values, valid bits and
// the flag, updated with plain arithmetic at every rising edge.
module tb_register_bank;

    localparam int BW = 8;
    localparam int RC = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear_all;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [1:0]    wr_mode;
    logic [BW-1:0] wr_data;
    logic          shift_in;
    logic [AW-1:0] rd_addr_a;
    logic [BW-1:0] rd_data_a;
    logic          rd_valid_a;
    logic [AW-1:0] rd_addr_b;
    logic [BW-1:0] rd_data_b;
    logic          rd_valid_b;
    logic          wr_flag;
    logic          addr_err;

    int m_val [RC];
    bit m_vld [RC];
    bit m_flag;
    bit m_err;
    int n_checks = 0;
    int n_fail   = 0;

    register_bank #(.BIT_COUNT(BW), .REG_COUNT(RC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_all  (clear_all),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_mode    (wr_mode),
        .wr_data    (wr_data),
        .shift_in   (shift_in),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b),
        .wr_flag    (wr_flag),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    function automatic void model_zero();
        for (int i = 0; i < RC; i++) begin
            m_val[i] = 0;
            m_vld[i] = 1'b0;
        end
        m_flag = 1'b0;
        m_err  = 1'b0;
    endfunction

    // Expected {valid, data} for a read address in the current cycle.
    function automatic logic [BW:0] expect_rd(input logic [AW-1:0] a);
        int idx;
        int v;
        idx = int'(a);
        if (idx >= RC) return '0;
`ifdef REGISTER_BANK_BYPASS_EN
        if (wr_en && !clear_all && wr_mode == 2'b00 && int'(wr_addr) == idx)
            return {1'b1, wr_data};
`endif
        v = m_val[idx];
        return {m_vld[idx], v[BW-1:0]};
    endfunction

    task automatic drive(input bit en, input int addr, input int mode,
                         input int data, input bit si, input bit clr);
        wr_en     = en;
        wr_addr   = AW'(addr);
        wr_mode   = 2'(mode);
        wr_data   = BW'(data);
        shift_in  = si;
        clear_all = clr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Advance one clock; the model takes the inputs present at the edge.
    task automatic tick();
        int a;
        int v;
        @(posedge clk);
        a     = int'(wr_addr);
        m_err = 1'b0;
        if (clear_all) begin
            for (int i = 0; i < RC; i++) begin
                m_val[i] = 0;
                m_vld[i] = 1'b0;
            end
            m_flag = 1'b0;
        end else if (wr_en) begin
            if (a >= RC) begin
                m_err = 1'b1;
            end else begin
                v = m_val[a];
                case (int'(wr_mode))
                    0: begin m_flag = 1'b0; v = int'(wr_data); end
                    1: begin m_flag = ((v / 128) % 2) == 1; v = ((v * 2) + int'(shift_in)) % 256; end
                    2: begin m_flag = (v % 2) == 1; v = (v / 2) + 128 * int'(shift_in); end
                    default: begin m_flag = (v == 255); v = (v + 1) % 256; end
                endcase
                m_val[a] = v;
                m_vld[a] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd4;
        model_zero();
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b0 || rd_data_b !== 8'h00 || rd_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_reads: got a=%h/%b b=%h/%b want 00/0 00/0", rd_data_a, rd_valid_a, rd_data_b, rd_valid_b);
        end
        n_checks++;
        if (wr_flag !== 1'b0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got flag=%b err=%b want 0 0", wr_flag, addr_err);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        drive(1'b1, 2, 0, 'hA5, 1'b0, 1'b0);
        tick();
        idle();
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd1;
        #1;
        n_checks++;
        if (rd_data_a !== 8'hA5 || rd_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL load_reg2: got %h/%b want a5/1", rd_data_a, rd_valid_a);
        end
        n_checks++;
        if (rd_data_b !== 8'h00 || rd_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL load_reg1_untouched: got %h/%b want 00/0", rd_data_b, rd_valid_b);
        end
    endtask

    task automatic test_shift();
        drive(1'b1, 0, 0, 'h81, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 1, 0, 1'b0, 1'b0);
        tick();
        idle();
        rd_addr_a = 3'd0;
        #1;
        n_checks++;
        if (rd_data_a !== 8'h02 || wr_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL shl: got %h flag=%b want 02 flag=1", rd_data_a, wr_flag);
        end
        drive(1'b1, 0, 2, 0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_data_a !== 8'h81 || wr_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL shr: got %h flag=%b want 81 flag=0", rd_data_a, wr_flag);
        end
    endtask

    task automatic test_incr();
        drive(1'b1, 3, 0, 'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3, 3, 0, 1'b0, 1'b0);
        tick();
        idle();
        rd_addr_b = 3'd3;
        #1;
        n_checks++;
        if (rd_data_b !== 8'h00 || rd_valid_b !== 1'b1 || wr_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL incr_wrap: got %h/%b flag=%b want 00/1 flag=1", rd_data_b, rd_valid_b, wr_flag);
        end
        drive(1'b1, 3, 3, 0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_data_b !== 8'h01 || wr_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_plain: got %h flag=%b want 01 flag=0", rd_data_b, wr_flag);
        end
    endtask

    task automatic test_out_of_range();
        logic [BW:0] e;
        // Set the flag so the out-of-range write can be seen not to touch it.
        drive(1'b1, 4, 0, 'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4, 3, 0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5, 0, 'h77, 1'b0, 1'b0);
        rd_addr_a = 3'd6;
        #1;
        n_checks++;
        if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_read: got %h/%b want 00/0", rd_data_a, rd_valid_a);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (addr_err !== 1'b1 || wr_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write: got err=%b flag=%b want err=1 flag=1", addr_err, wr_flag);
        end
        for (int i = 0; i < RC; i++) begin
            rd_addr_b = AW'(i);
            #1;
            e = expect_rd(rd_addr_b);
            n_checks++;
            if ({rd_valid_b, rd_data_b} !== e) begin
                n_fail++;
                $display("FAIL oor_no_change reg%0d: got %h/%b want %h/%b", i, rd_data_b, rd_valid_b, e[BW-1:0], e[BW]);
            end
        end
        tick();
        n_checks++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_pulse_width: got err=%b want 0", addr_err);
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 1, 0, 'h55, 1'b0, 1'b1);
        rd_addr_b = 3'd1;
        #1;
        n_checks++;
        if (rd_data_b !== 8'h00 || rd_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_blocks_forward: got %h/%b want 00/0", rd_data_b, rd_valid_b);
        end
        tick();
        idle();
        for (int i = 0; i < RC; i++) begin
            rd_addr_a = AW'(i);
            #1;
            n_checks++;
            if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_reg%0d: got %h/%b want 00/0", i, rd_data_a, rd_valid_a);
            end
        end
        n_checks++;
        if (wr_flag !== 1'b0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_status: got flag=%b err=%b want 0 0", wr_flag, addr_err);
        end
        drive(1'b1, 7, 0, 'h12, 1'b0, 1'b1);
        tick();
        idle();
        n_checks++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_suppresses_err: got err=%b want 0", addr_err);
        end
    endtask

    task automatic test_bypass();
        logic [BW-1:0] want;
        drive(1'b1, 1, 0, 'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1, 0, 'h3C, 1'b0, 1'b0);
        rd_addr_b = 3'd1;
        rd_addr_a = 3'd1;
        #1;
`ifdef REGISTER_BANK_BYPASS_EN
        want = 8'h3C;
`else
        want = 8'h11;
`endif
        n_checks++;
        if (rd_data_b !== want || rd_valid_b !== 1'b1 || rd_data_a !== want) begin
            n_fail++;
            $display("FAIL bypass_load: got a=%h b=%h/%b want %h/1", rd_data_a, rd_data_b, rd_valid_b, want);
        end
        tick();
        drive(1'b1, 1, 1, 0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (rd_data_b !== 8'h3C) begin
            n_fail++;
            $display("FAIL bypass_shl_not_forwarded: got %h want 3c", rd_data_b);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [BW:0] ea;
        logic [BW:0] eb;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
            rd_addr_a = AW'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
            #1;
            ea = expect_rd(rd_addr_a);
            eb = expect_rd(rd_addr_b);
            n_checks++;
            if ({rd_valid_a, rd_data_a} !== ea || {rd_valid_b, rd_data_b} !== eb) begin
                n_fail++;
                $display("FAIL rand_read n=%0d: got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b", n,
                         rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, ea[BW-1:0], ea[BW], eb[BW-1:0], eb[BW]);
            end
            n_checks++;
            if (wr_flag !== m_flag || addr_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_status n=%0d: got flag=%b err=%b want flag=%b err=%b", n, wr_flag, addr_err, m_flag, m_err);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 0, 0, 'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 0, 3, 0, 1'b0, 1'b0);
        tick();
        idle();
        rd_addr_a = 3'd0;
        #2;
        reset_n = 1'b0;
        model_zero();
        #1;
        n_checks++;
        if (rd_data_a !== 8'h00 || rd_valid_a !== 1'b0 || wr_flag !== 1'b0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%b flag=%b err=%b want 00/0 0 0", rd_data_a, rd_valid_a, wr_flag, addr_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 0, 0, 'h42, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_data_a !== 8'h42 || rd_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL write_after_reset: got %h/%b want 42/1", rd_data_a, rd_valid_a);
        end
    endtask

    initial begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        test_reset();
        test_load();
        test_shift();
        test_incr();
        test_out_of_range();
        test_clear();
        test_bypass();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_bank
